multicycle_control: RTL and testbench

Main control unit for the multi-cycle MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It decodes the 6-bit opcode and drives every datapath enable and mux select. It is the producer of the 2-bit `ALUOp` consumed by `ALU_control`, which resolves it together with the funct field into the 4-bit ALU operation.

---
 rtl/multicycle_control_pkg.sv | 62 ++++++
 rtl/control_output_decode.sv | 80 ++++++++
 rtl/multicycle_control.sv | 102 ++++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control unit.
// Opcodes, ALUOp codes, state encodings and the control word layout.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/control_output_decode.sv
// Moore output map: turns the current control state into the datapath
// control word. Unused state codes yield an all-zero word.
module control_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFFS;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_OUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state logic and reset gating of the decoded control word.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t cur;
    state_t nxt;
    ctrl_t  raw;
    ctrl_t  word;

    logic is_mem;
    logic is_rtype;
    logic is_beq;
    logic is_j;
    logic is_addi;

    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_addi  = (opcode == OP_ADDI);

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH: nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:   nxt = S_MEM_ADDR;
                    is_rtype: nxt = S_EXECUTE;
                    is_beq:   nxt = S_BRANCH;
                    is_j:     nxt = S_JUMP;
                    is_addi:  nxt = S_ADDI_EXEC;
                    default:  nxt = S_FETCH;
                endcase
            end
            // Only lw and sw reach here; anything but sw is treated as lw.
            S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  nxt = S_MEM_WB;
            S_EXECUTE:   nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            default:     nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    control_output_decode u_decode (
        .state (cur),
        .ctrl  (raw)
    );

    // Reset kills every enable in the same cycle so no partial write-back
    // can leak out of an interrupted instruction.
    assign word = reset ? '0 : raw;

    assign PCWrite     = word.pc_write;
    assign PCWriteCond = word.pc_write_cond;
    assign IorD        = word.iord;
    assign MemRead     = word.mem_read;
    assign MemWrite    = word.mem_write;
    assign IRWrite     = word.ir_write;
    assign MemtoReg    = word.mem_to_reg;
    assign RegDst      = word.reg_dst;
    assign RegWrite    = word.reg_write;
    assign ALUSrcA     = word.alu_src_a;
    assign ALUSrcB     = word.alu_src_b;
    assign ALUOp       = word.alu_op;
    assign PCSource    = word.pc_source;
    assign instr_done  = word.instr_done;

    assign illegal_op = !reset && (cur == S_DECODE) && !op_legal(opcode);
    assign state      = reset ? 4'd0 : cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-opcode state path model
// plus per-state output table, checked every cycle, with literal spot checks.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int total = 0;
    int passed = 0;
    int done_cnt = 0;

    logic       exp_valid = 1'b0;
    logic       exp_rst = 1'b0;
    int         exp_state = 0;
    logic [5:0] cur_op = 6'd0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    logic [16:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, instr_done};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Output table: what each state asserts, listed by signal name.
    function automatic logic [16:0] expect_outs(input int st);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, done;
        logic [1:0] sb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, done} = '0;
        sb = 2'b00;
        aop = 2'b00;
        psrc = 2'b00;
        case (st)
            0: begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; end
            1: sb = 2'b11;
            2: begin sa = 1; sb = 2'b10; end
            3: begin mr = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; done = 1; end
            5: begin mw = 1; iord = 1; done = 1; end
            6: begin sa = 1; aop = 2'b10; end
            7: begin rw = 1; rd = 1; done = 1; end
            8: begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
            9: begin pcw = 1; psrc = 2'b10; done = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop,
                psrc, done};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            if (exp_rst) begin
                check("rst_state", 32'(state), 32'd0);
                check("rst_outs", 32'(obs), 32'd0);
                check("rst_illegal", 32'(illegal_op), 32'd0);
            end else begin
                check("state", 32'(state), 32'(exp_state));
                check("outs", 32'(obs), 32'(expect_outs(exp_state)));
                check("illegal", 32'(illegal_op),
                      32'(exp_state == 1 && !legal(cur_op)));
            end
            if (instr_done) done_cnt++;
        end
    end

    task automatic step(input int st, input logic [5:0] op,
                        input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        opcode = op;
        cur_op = op;
        exp_state = st;
        exp_rst = rst;
        exp_valid = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op);
        int path[$];
        done_cnt = 0;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b001000: path = '{0, 1, 10, 11};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            default:   path = '{0, 1};
        endcase
        foreach (path[i]) step(path[i], op, 1'b0);
    endtask

    initial begin
        repeat (3) step(0, 6'd0, 1'b1);

        // First lw after reset, with literal spot checks.
        done_cnt = 0;
        step(0, 6'b100011, 1'b0);
        check("fetch_memread", 32'(MemRead), 32'd1);
        check("fetch_irwrite", 32'(IRWrite), 32'd1);
        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
        check("fetch_srcb", 32'(ALUSrcB), 32'd1);
        check("fetch_aluop", 32'(ALUOp), 32'd0);
        step(1, 6'b100011, 1'b0);
        step(2, 6'b100011, 1'b0);
        step(3, 6'b100011, 1'b0);
        step(4, 6'b100011, 1'b0);
        check("lw_wb_regwrite", 32'(RegWrite), 32'd1);
        check("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
        check("lw_done_count", 32'(done_cnt), 32'd1);

        run_instr(6'b000000);
        check("r_done_count", 32'(done_cnt), 32'd1);
        run_instr(6'b101011);
        check("sw_done_count", 32'(done_cnt), 32'd1);

        done_cnt = 0;
        step(0, 6'b000100, 1'b0);
        step(1, 6'b000100, 1'b0);
        step(8, 6'b000100, 1'b0);
        check("beq_aluop", 32'(ALUOp), 32'd1);
        check("beq_pcwc", 32'(PCWriteCond), 32'd1);
        check("beq_pcsrc", 32'(PCSource), 32'd1);
        check("beq_done_count", 32'(done_cnt), 32'd1);

        run_instr(6'b000010);
        check("j_done_count", 32'(done_cnt), 32'd1);

        done_cnt = 0;
        step(0, 6'b111111, 1'b0);
        step(1, 6'b111111, 1'b0);
        check("illegal_pulse", 32'(illegal_op), 32'd1);
        check("illegal_no_done", 32'(instr_done), 32'd0);
        check("illegal_done_count", 32'(done_cnt), 32'd0);

        run_instr(6'b001000);
        check("addi_done_count", 32'(done_cnt), 32'd1);

        // Reset lands while the lw sits in MEM_READ.
        done_cnt = 0;
        step(0, 6'b100011, 1'b0);
        step(1, 6'b100011, 1'b0);
        step(2, 6'b100011, 1'b0);
        step(3, 6'b100011, 1'b1);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_memread", 32'(MemRead), 32'd0);
        check("midrst_done_count", 32'(done_cnt), 32'd0);
        run_instr(6'b100011);
        check("lw_after_rst_done", 32'(done_cnt), 32'd1);

        run_instr(6'b011111);
        run_instr(6'b000000);
        run_instr(6'b101011);

        exp_valid = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
